// File: rtl/mul_share_arb_pkg.sv
// ----------------------------------------------------------------------------
// mul_share_arb_pkg
// Shared definitions for the two-requester multiplier-sharing arbiter:
//   - LAT_DEF    : default multiplier pipeline latency (operands -> mul_prod)
//   - STAT_W_DEF : default statistics counter width
//   - ID_W       : requester-id width
//   - tag_t      : in-flight tag {valid, id} carried alongside the multiplier
// ----------------------------------------------------------------------------
package mul_share_arb_pkg;

    localparam int LAT_DEF    = 3;
    localparam int STAT_W_DEF = 16;
    localparam int ID_W       = 1;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage : mul_share_arb_pkg

// File: rtl/mul_share_arb_rr.sv
// ----------------------------------------------------------------------------
// mul_share_arb_rr
// Two-way round-robin picker, purely combinational.
//   valid_i[1:0] : requester valid bits
//   ptr_i        : requester favoured when both are valid (0 or 1)
//   grant_o[1:0] : one-hot (or zero) grant
// ----------------------------------------------------------------------------
module mul_share_arb_rr
    import mul_share_arb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o
);

    // Grant the lone requester, or the favoured one under contention.
    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11: begin
                if (ptr_i) begin
                    grant_o = 2'b10;
                end else begin
                    grant_o = 2'b01;
                end
            end
            default: grant_o = 2'b00;
        endcase
    end

endmodule : mul_share_arb_rr

// File: rtl/mul_share_arb.sv
// ----------------------------------------------------------------------------
// mul_share_arb
// Shares one external pipelined 4x4 multiplier (latency LAT) between two
// requesters. A round-robin picker grants one requester per cycle; its
// operands are muxed onto mul_a/mul_b and a {valid,id} tag travels down a
// LAT-deep shift register so that mul_prod can be steered back to the right
// response port. Responses are one-cycle pulses, LAT+1 cycles after transfer.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   reqN_valid/reqN_ready           request handshake (N = 0,1)
//   reqN_a, reqN_b                  4-bit unsigned operands
//   rspN_valid/rspN_prod            response pulse and 8-bit product
//   mul_a, mul_b / mul_prod         shared multiplier interface
//   busy                            any operation accepted but not answered
//   stat_gnt0/1, stat_conflict      saturating statistics counters
//
// Configuration macro: MUL_SHARE_ARB_STATS_EN
//   defined   -> statistics counters are implemented
//   undefined -> stat ports are tied to zero, no counter flops
// ----------------------------------------------------------------------------
module mul_share_arb
    import mul_share_arb_pkg::*;
#(
    parameter int LAT    = LAT_DEF,
    parameter int STAT_W = STAT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [3:0]        req0_a,
    input  logic [3:0]        req0_b,
    input  logic [3:0]        req1_a,
    input  logic [3:0]        req1_b,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [7:0]        rsp0_prod,
    output logic [7:0]        rsp1_prod,
    output logic [3:0]        mul_a,
    output logic [3:0]        mul_b,
    input  logic [7:0]        mul_prod,
    output logic              busy,
    output logic [STAT_W-1:0] stat_gnt0,
    output logic [STAT_W-1:0] stat_gnt1,
    output logic [STAT_W-1:0] stat_conflict
);

    logic [1:0]          valid_s;
    logic [1:0]          grant_s;
    logic                xfer_s;
    logic [ID_W-1:0]     gnt_id_s;
    logic                ptr_q;
    logic                ptr_d;
    tag_t [LAT-1:0]      tag_q;
    tag_t [LAT-1:0]      tag_d;
    logic [1:0]          rsp_valid_q;
    logic [1:0]          rsp_valid_d;
    logic [7:0]          rsp0_prod_q;
    logic [7:0]          rsp0_prod_d;
    logic [7:0]          rsp1_prod_q;
    logic [7:0]          rsp1_prod_d;
    logic                tag_busy_s;

    // Valids are masked while reset is asserted so no grant leaks out.
    assign valid_s = {req1_valid, req0_valid} & {2{rst_n}};

    mul_share_arb_rr u_rr (
        .valid_i (valid_s),
        .ptr_i   (ptr_q),
        .grant_o (grant_s)
    );

    assign req0_ready = grant_s[0];
    assign req1_ready = grant_s[1];
    assign xfer_s     = grant_s[0] | grant_s[1];
    assign gnt_id_s   = grant_s[1];

    // Operand mux; an idle cycle sends a zero bubble into the multiplier.
    always_comb begin
        mul_a = 4'd0;
        mul_b = 4'd0;
        if (grant_s[0]) begin
            mul_a = req0_a;
            mul_b = req0_b;
        end else if (grant_s[1]) begin
            mul_a = req1_a;
            mul_b = req1_b;
        end else begin
            mul_a = 4'd0;
            mul_b = 4'd0;
        end
    end

    // Pointer next state: after a transfer the other requester is favoured.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer_s) begin
            ptr_d = ~gnt_id_s;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Tag pipeline next state: stage 0 takes this cycle's transfer (or a bubble).
    always_comb begin
        tag_d          = tag_q;
        tag_d[0].valid = xfer_s;
        tag_d[0].id    = gnt_id_s;
        for (int i = 1; i < LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Response capture: the last tag stage lines up with mul_prod this cycle.
    always_comb begin
        rsp_valid_d = 2'b00;
        rsp0_prod_d = rsp0_prod_q;
        rsp1_prod_d = rsp1_prod_q;
        if (tag_q[LAT-1].valid) begin
            if (tag_q[LAT-1].id == 1'b0) begin
                rsp_valid_d[0] = 1'b1;
                rsp0_prod_d    = mul_prod;
            end else begin
                rsp_valid_d[1] = 1'b1;
                rsp1_prod_d    = mul_prod;
            end
        end else begin
            rsp_valid_d = 2'b00;
        end
    end

    // State registers for pointer, tags and responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= 1'b0;
            tag_q       <= '0;
            rsp_valid_q <= 2'b00;
            rsp0_prod_q <= 8'd0;
            rsp1_prod_q <= 8'd0;
        end else begin
            ptr_q       <= ptr_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp0_prod_q <= rsp0_prod_d;
            rsp1_prod_q <= rsp1_prod_d;
        end
    end

    // OR-reduce the tag valid bits for busy.
    always_comb begin
        tag_busy_s = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            tag_busy_s = tag_busy_s | tag_q[i].valid;
        end
    end

    assign busy       = tag_busy_s | rsp_valid_q[0] | rsp_valid_q[1];
    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_prod  = rsp0_prod_q;
    assign rsp1_prod  = rsp1_prod_q;

`ifdef MUL_SHARE_ARB_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    logic [STAT_W-1:0] gnt0_q;
    logic [STAT_W-1:0] gnt0_d;
    logic [STAT_W-1:0] gnt1_q;
    logic [STAT_W-1:0] gnt1_d;
    logic [STAT_W-1:0] conf_q;
    logic [STAT_W-1:0] conf_d;

    // Saturating increment, holding at all-ones.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                  input logic              en);
        logic [STAT_W-1:0] r;
        if (en && (v != STAT_MAX)) begin
            r = v + STAT_ONE;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Counter next state: grants per requester and contended cycles.
    always_comb begin
        gnt0_d = sat_inc(gnt0_q, grant_s[0]);
        gnt1_d = sat_inc(gnt1_q, grant_s[1]);
        conf_d = sat_inc(conf_q, valid_s[0] & valid_s[1]);
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0_q <= '0;
            gnt1_q <= '0;
            conf_q <= '0;
        end else begin
            gnt0_q <= gnt0_d;
            gnt1_q <= gnt1_d;
            conf_q <= conf_d;
        end
    end

    assign stat_gnt0     = gnt0_q;
    assign stat_gnt1     = gnt1_q;
    assign stat_conflict = conf_q;
`else
    assign stat_gnt0     = '0;
    assign stat_gnt1     = '0;
    assign stat_conflict = '0;
`endif

endmodule : mul_share_arb

// File: tb/tb_mul_share_arb.sv
// ----------------------------------------------------------------------------
// tb_mul_share_arb
// Self-checking bench for mul_share_arb with a 3-cycle reference multiplier.
// Expected grants, responses, busy and statistics come from a cycle-indexed
// scoreboard: each accepted operation is booked as a pulse LAT+1 cycles later.
// Honours MUL_SHARE_ARB_STATS_EN for the statistics expectations.
// ----------------------------------------------------------------------------
module tb_mul_share_arb;

    localparam int LAT    = 3;
    localparam int STAT_W = 4;
    localparam int SMAX   = 15;

    logic              clk;
    logic              rst_n;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [3:0]        req0_a, req0_b, req1_a, req1_b;
    logic              rsp0_valid, rsp1_valid;
    logic [7:0]        rsp0_prod, rsp1_prod;
    logic [3:0]        mul_a, mul_b;
    logic [7:0]        mul_prod;
    logic              busy;
    logic [STAT_W-1:0] stat_gnt0, stat_gnt1, stat_conflict;

    mul_share_arb #(.LAT(LAT), .STAT_W(STAT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0_valid    (req0_valid),
        .req1_valid    (req1_valid),
        .req0_ready    (req0_ready),
        .req1_ready    (req1_ready),
        .req0_a        (req0_a),
        .req0_b        (req0_b),
        .req1_a        (req1_a),
        .req1_b        (req1_b),
        .rsp0_valid    (rsp0_valid),
        .rsp1_valid    (rsp1_valid),
        .rsp0_prod     (rsp0_prod),
        .rsp1_prod     (rsp1_prod),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_prod      (mul_prod),
        .busy          (busy),
        .stat_gnt0     (stat_gnt0),
        .stat_gnt1     (stat_gnt1),
        .stat_conflict (stat_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference pipelined multiplier, LAT register stages.
    logic [7:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= {4'd0, mul_a} * {4'd0, mul_b};
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_prod = mpipe[LAT-1];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: pulses booked by absolute cycle in a 16-slot ring.
    int         cyc;
    int         favour;
    int         last_acc;
    logic       sched_v [2][16];
    logic [7:0] sched_p [2][16];
    logic [7:0] exp_prod [2];
    int         cnt_g0, cnt_g1, cnt_c;

    function automatic int sat(input int x);
        return (x < SMAX) ? x + 1 : x;
    endfunction

    task automatic model_reset();
        favour   = 0;
        last_acc = -100;
        for (int n = 0; n < 2; n++) begin
            exp_prod[n] = 8'd0;
            for (int s = 0; s < 16; s++) begin
                sched_v[n][s] = 1'b0;
                sched_p[n][s] = 8'd0;
            end
        end
        cnt_g0 = 0;
        cnt_g1 = 0;
        cnt_c  = 0;
    endtask

    task automatic check_stats();
`ifdef MUL_SHARE_ARB_STATS_EN
        check("stat_gnt0", 16'(stat_gnt0), 16'(cnt_g0));
        check("stat_gnt1", 16'(stat_gnt1), 16'(cnt_g1));
        check("stat_conflict", 16'(stat_conflict), 16'(cnt_c));
`else
        check("stat_gnt0_tied", 16'(stat_gnt0), 16'd0);
        check("stat_gnt1_tied", 16'(stat_gnt1), 16'd0);
        check("stat_conflict_tied", 16'(stat_conflict), 16'd0);
`endif
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, book, advance.
    task automatic cycle(input logic v0, input logic v1,
                         input logic [3:0] a0, input logic [3:0] b0,
                         input logic [3:0] a1, input logic [3:0] b1);
        logic eg0, eg1;
        logic [3:0] ea, eb;
        int slot, id, s;
        req0_valid = v0; req1_valid = v1;
        req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
        @(negedge clk);
        eg0 = 1'b0; eg1 = 1'b0;
        if (v0 && v1) begin
            if (favour == 0) eg0 = 1'b1; else eg1 = 1'b1;
        end else if (v0) eg0 = 1'b1;
        else if (v1) eg1 = 1'b1;
        check("req0_ready", 16'(req0_ready), 16'(eg0));
        check("req1_ready", 16'(req1_ready), 16'(eg1));
        ea = eg0 ? a0 : (eg1 ? a1 : 4'd0);
        eb = eg0 ? b0 : (eg1 ? b1 : 4'd0);
        check("mul_a", 16'(mul_a), 16'(ea));
        check("mul_b", 16'(mul_b), 16'(eb));
        slot = cyc % 16;
        for (int n = 0; n < 2; n++) if (sched_v[n][slot]) exp_prod[n] = sched_p[n][slot];
        check("rsp0_valid", 16'(rsp0_valid), 16'(sched_v[0][slot]));
        check("rsp1_valid", 16'(rsp1_valid), 16'(sched_v[1][slot]));
        check("rsp0_prod", 16'(rsp0_prod), 16'(exp_prod[0]));
        check("rsp1_prod", 16'(rsp1_prod), 16'(exp_prod[1]));
        sched_v[0][slot] = 1'b0;
        sched_v[1][slot] = 1'b0;
        check("busy", 16'(busy), 16'(cyc <= last_acc + LAT + 1));
        check_stats();
        if (eg0 || eg1) begin
            id = eg1 ? 1 : 0;
            s  = (cyc + LAT + 1) % 16;
            sched_v[id][s] = 1'b1;
            sched_p[id][s] = 8'(ea * eb);
            favour   = 1 - id;
            last_acc = cyc;
            if (id == 0) cnt_g0 = sat(cnt_g0); else cnt_g1 = sat(cnt_g1);
        end
        if (v0 && v1) cnt_c = sat(cnt_c);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Assert reset away from the edge, check reset outputs, hold, release.
    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rst_ready0", 16'(req0_ready), 16'd0);
        check("rst_ready1", 16'(req1_ready), 16'd0);
        check("rst_mul_a", 16'(mul_a), 16'd0);
        check("rst_mul_b", 16'(mul_b), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_rsp_v", 16'({rsp1_valid, rsp0_valid}), 16'd0);
        check("rst_rsp_p", {rsp1_prod, rsp0_prod}, 16'd0);
        check("rst_stat", 16'(stat_gnt0 | stat_gnt1 | stat_conflict), 16'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 4'd0; req0_b = 4'd0; req1_a = 4'd0; req1_b = 4'd0;
        cyc = 0;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // Single req0 transfer right after reset release: 9*7 = 63.
        cycle(1'b1, 1'b0, 4'd9, 4'd7, 4'd0, 4'd0);
        repeat (6) cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        check("single_prod63", 16'(rsp0_prod), 16'd63);

        // Continuous contention: alternating 15 and 225.
        repeat (10) cycle(1'b1, 1'b1, 4'd3, 4'd5, 4'd15, 4'd15);
        repeat (6) cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        check("alt_prod0", 16'(rsp0_prod), 16'd15);
        check("alt_prod1", 16'(rsp1_prod), 16'd225);

        // req1 alone, then contention: req0 must win first.
        repeat (4) cycle(1'b0, 1'b1, 4'd0, 4'd0, 4'd2, 4'd3);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("contend_first_r0", 16'({req1_ready, req0_ready}), 16'd1);
        repeat (4) cycle(1'b1, 1'b1, 4'd4, 4'd4, 4'd2, 4'd3);
        repeat (6) cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);

        // Mid-operation reset after two transfers: nothing may come back.
        cycle(1'b1, 1'b0, 4'd6, 4'd6, 4'd0, 4'd0);
        cycle(1'b0, 1'b1, 4'd0, 4'd0, 4'd7, 4'd7);
        do_reset();
        repeat (8) cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);

        // 20 contended cycles from a clean reset: counters saturate / split.
        do_reset();
        repeat (20) cycle(1'b1, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        repeat (6) cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
`ifdef MUL_SHARE_ARB_STATS_EN
        check("sat_conflict15", 16'(stat_conflict), 16'd15);
        check("sat_gnt0_10", 16'(stat_gnt0), 16'd10);
        check("sat_gnt1_10", 16'(stat_gnt1), 16'd10);
`else
        check("nostat_all0", 16'(stat_gnt0 | stat_gnt1 | stat_conflict), 16'd0);
`endif

        // Randomised traffic against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end
        repeat (6) cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mul_share_arb
